// File: rtl/masked_cam.sv
// Masked CAM: DEPTH x WIDTH entries with per-entry valid bits, indexed/allocating
// write, invalidate, indexed read and don't-care search; all results registered.

module masked_cam_entry #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic [WIDTH-1:0] i_key,
   input  logic [WIDTH-1:0] i_mask,
   input  logic             i_valid,
   output logic             o_match
);
   assign o_match = i_valid && (((i_data ^ i_key) & i_mask) == '0);
endmodule

module masked_cam #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  read_enable_i,
   input  logic [ADDR_WIDTH-1:0] read_index_i,
   input  logic                  write_enable_i,
   input  logic [ADDR_WIDTH-1:0] write_index_i,
   input  logic [WIDTH-1:0]      write_data_i,
   input  logic                  alloc_enable_i,
   input  logic                  inval_enable_i,
   input  logic [ADDR_WIDTH-1:0] inval_index_i,
   input  logic                  search_enable_i,
   input  logic [WIDTH-1:0]      search_data_i,
   input  logic [WIDTH-1:0]      search_mask_i,
   output logic                  read_valid_o,
   output logic [WIDTH-1:0]      read_value_o,
   output logic                  search_valid_o,
   output logic [ADDR_WIDTH-1:0] search_index_o,
   output logic                  search_multi_o,
   output logic                  alloc_done_o,
   output logic                  alloc_fail_o,
   output logic [ADDR_WIDTH-1:0] alloc_index_o,
   output logic                  full_o,
   output logic [ADDR_WIDTH:0]   count_o
);
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

   logic [WIDTH-1:0]      r_data [DEPTH];
   logic [DEPTH-1:0]      r_valid;

   logic                  r_read_valid;
   logic [WIDTH-1:0]      r_read_value;
   logic                  r_search_valid;
   logic [ADDR_WIDTH-1:0] r_search_index;
   logic                  r_search_multi;
   logic                  r_alloc_done;
   logic                  r_alloc_fail;
   logic [ADDR_WIDTH-1:0] r_alloc_index;
   logic                  r_full;
   logic [ADDR_WIDTH:0]   r_count;

   logic [DEPTH-1:0]      w_match;
   logic                  w_wr_ok;
   logic                  w_inv_ok;
   logic                  w_rd_ok;
   logic                  w_free_any;
   logic [ADDR_WIDTH-1:0] w_free_idx;
   logic                  w_hit;
   logic                  w_multi;
   logic [ADDR_WIDTH-1:0] w_hit_idx;
   logic                  w_alloc_go;
   logic [DEPTH-1:0]      w_valid_nxt;
   logic [ADDR_WIDTH:0]   w_count;

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_entry
         masked_cam_entry #(.WIDTH(WIDTH)) u_entry (
            .i_data  (r_data[g]),
            .i_key   (search_data_i),
            .i_mask  (search_mask_i),
            .i_valid (r_valid[g]),
            .o_match (w_match[g])
         );
      end
   endgenerate

   always_comb begin
      w_wr_ok  = write_enable_i && ({1'b0, write_index_i} < DEPTH_L);
      w_inv_ok = inval_enable_i && ({1'b0, inval_index_i} < DEPTH_L);
      w_rd_ok  = read_enable_i  && ({1'b0, read_index_i}  < DEPTH_L);

      // Lowest free entry; downward scan leaves the smallest index last.
      w_free_any = 1'b0;
      w_free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_free_any = 1'b1;
            w_free_idx = ADDR_WIDTH'(i);
         end
      end

      w_hit     = 1'b0;
      w_multi   = 1'b0;
      w_hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_match[i]) begin
            if (w_hit) w_multi = 1'b1;
            else begin
               w_hit     = 1'b1;
               w_hit_idx = ADDR_WIDTH'(i);
            end
         end
      end

      // An indexed write in the same cycle pre-empts allocation.
      w_alloc_go = alloc_enable_i && !write_enable_i && w_free_any;

      // Invalidate first so a write to the same index wins.
      w_valid_nxt = r_valid;
      if (w_inv_ok)   w_valid_nxt[inval_index_i] = 1'b0;
      if (w_wr_ok)    w_valid_nxt[write_index_i] = 1'b1;
      if (w_alloc_go) w_valid_nxt[w_free_idx]    = 1'b1;

      w_count = '0;
      for (int i = 0; i < DEPTH; i++)
         w_count = w_count + (ADDR_WIDTH+1)'(w_valid_nxt[i]);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
         r_valid        <= '0;
         r_read_valid   <= 1'b0;
         r_read_value   <= '0;
         r_search_valid <= 1'b0;
         r_search_index <= '0;
         r_search_multi <= 1'b0;
         r_alloc_done   <= 1'b0;
         r_alloc_fail   <= 1'b0;
         r_alloc_index  <= '0;
         r_full         <= 1'b0;
         r_count        <= '0;
      end else begin
         if (w_wr_ok)         r_data[write_index_i] <= write_data_i;
         else if (w_alloc_go) r_data[w_free_idx]    <= write_data_i;
         r_valid <= w_valid_nxt;

         if (w_rd_ok && r_valid[read_index_i]) begin
            r_read_valid <= 1'b1;
            r_read_value <= r_data[read_index_i];
         end else begin
            r_read_valid <= 1'b0;
            r_read_value <= '0;
         end

         r_search_valid <= search_enable_i && w_hit;
         r_search_index <= (search_enable_i && w_hit) ? w_hit_idx : '0;
         r_search_multi <= search_enable_i && w_multi;

         r_alloc_done  <= w_alloc_go;
         r_alloc_fail  <= alloc_enable_i && !w_alloc_go;
         r_alloc_index <= w_alloc_go ? w_free_idx : '0;

         r_count <= w_count;
         r_full  <= (w_count == DEPTH_L);
      end
   end

   assign read_valid_o   = r_read_valid;
   assign read_value_o   = r_read_value;
   assign search_valid_o = r_search_valid;
   assign search_index_o = r_search_index;
   assign search_multi_o = r_search_multi;
   assign alloc_done_o   = r_alloc_done;
   assign alloc_fail_o   = r_alloc_fail;
   assign alloc_index_o  = r_alloc_index;
   assign full_o         = r_full;
   assign count_o        = r_count;
endmodule

// File: tb/tb_masked_cam.sv
// Directed bench for masked_cam: a DEPTH=32 and a DEPTH=20 instance share one
// stimulus stream; expected values are hand-computed per cycle.

module tb_masked_cam;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        re, we, ae, ie, se;
   logic [4:0]  ridx, widx, iidx;
   logic [31:0] wdata, sdata, smask;

   logic        a_rv, a_sv, a_sm, a_ad, a_af, a_full;
   logic [31:0] a_rval;
   logic [4:0]  a_sidx, a_aidx;
   logic [5:0]  a_cnt;
   logic        b_rv, b_sv, b_sm, b_ad, b_af, b_full;
   logic [31:0] b_rval;
   logic [4:0]  b_sidx, b_aidx;
   logic [5:0]  b_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   masked_cam #(.WIDTH(32), .DEPTH(32)) u32 (
      .clk_i(clk), .rst_i(rst),
      .read_enable_i(re), .read_index_i(ridx),
      .write_enable_i(we), .write_index_i(widx), .write_data_i(wdata),
      .alloc_enable_i(ae), .inval_enable_i(ie), .inval_index_i(iidx),
      .search_enable_i(se), .search_data_i(sdata), .search_mask_i(smask),
      .read_valid_o(a_rv), .read_value_o(a_rval),
      .search_valid_o(a_sv), .search_index_o(a_sidx), .search_multi_o(a_sm),
      .alloc_done_o(a_ad), .alloc_fail_o(a_af), .alloc_index_o(a_aidx),
      .full_o(a_full), .count_o(a_cnt));

   masked_cam #(.WIDTH(32), .DEPTH(20)) u20 (
      .clk_i(clk), .rst_i(rst),
      .read_enable_i(re), .read_index_i(ridx),
      .write_enable_i(we), .write_index_i(widx), .write_data_i(wdata),
      .alloc_enable_i(ae), .inval_enable_i(ie), .inval_index_i(iidx),
      .search_enable_i(se), .search_data_i(sdata), .search_mask_i(smask),
      .read_valid_o(b_rv), .read_value_o(b_rval),
      .search_valid_o(b_sv), .search_index_o(b_sidx), .search_multi_o(b_sm),
      .alloc_done_o(b_ad), .alloc_fail_o(b_af), .alloc_index_o(b_aidx),
      .full_o(b_full), .count_o(b_cnt));

   wire [53:0] act32 = {a_rv, a_rval, a_sv, a_sidx, a_sm, a_ad, a_af, a_aidx, a_full, a_cnt};
   wire [53:0] act20 = {b_rv, b_rval, b_sv, b_sidx, b_sm, b_ad, b_af, b_aidx, b_full, b_cnt};

   typedef struct {
      logic we; logic [4:0] widx; logic [31:0] wdata;
      logic ae; logic ie; logic [4:0] iidx;
      logic re; logic [4:0] ridx;
      logic se; logic [31:0] sdata; logic [31:0] smask;
      logic x_rv; logic [31:0] x_rval;
      logic x_sv; logic [4:0] x_sidx; logic x_sm;
      logic x_ad; logic x_af; logic [4:0] x_aidx;
      logic x_full; logic [5:0] x_cnt;
   } vec_t;

   function automatic vec_t V(int w, int wi, logic [31:0] wd, int a, int i, int ii,
                              int r, int ri, int s, logic [31:0] sd, logic [31:0] sm,
                              int rv, logic [31:0] rval, int sv, int si, int mu,
                              int ad, int af, int ai, int fu, int cn);
      vec_t v;
      v.we = w[0]; v.widx = wi[4:0]; v.wdata = wd;
      v.ae = a[0]; v.ie = i[0]; v.iidx = ii[4:0];
      v.re = r[0]; v.ridx = ri[4:0];
      v.se = s[0]; v.sdata = sd; v.smask = sm;
      v.x_rv = rv[0]; v.x_rval = rval;
      v.x_sv = sv[0]; v.x_sidx = si[4:0]; v.x_sm = mu[0];
      v.x_ad = ad[0]; v.x_af = af[0]; v.x_aidx = ai[4:0];
      v.x_full = fu[0]; v.x_cnt = cn[5:0];
      return v;
   endfunction

   function automatic logic [53:0] pk(vec_t v);
      return {v.x_rv, v.x_rval, v.x_sv, v.x_sidx, v.x_sm, v.x_ad, v.x_af, v.x_aidx, v.x_full, v.x_cnt};
   endfunction

   task automatic drive(vec_t v);
      we = v.we; widx = v.widx; wdata = v.wdata;
      ae = v.ae; ie = v.ie; iidx = v.iidx;
      re = v.re; ridx = v.ridx;
      se = v.se; sdata = v.sdata; smask = v.smask;
   endtask

   task automatic chk(string nm, logic [53:0] act, logic [53:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   vec_t tbl [22];
   vec_t idle, v, e20;

   initial begin
      idle = V(0,0,0, 0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,0);
      //           we wi wdata       ae ie ii re ri se sdata        smask         rv rval          sv si mu ad af ai fu cnt
      tbl[0]  = V(1,3,32'hDEADBEEF, 0, 0,0, 0,0, 0,0,0,                          0,0,             0,0,0, 0,0,0, 0,1);
      tbl[1]  = V(0,0,0,            0, 0,0, 1,3, 0,0,0,                          1,32'hDEADBEEF,  0,0,0, 0,0,0, 0,1);
      tbl[2]  = V(1,5,32'h123400AA, 0, 0,0, 0,0, 0,0,0,                          0,0,             0,0,0, 0,0,0, 0,2);
      tbl[3]  = V(1,9,32'h123400BB, 0, 0,0, 0,0, 0,0,0,                          0,0,             0,0,0, 0,0,0, 0,3);
      tbl[4]  = V(0,0,0,            0, 0,0, 0,0, 1,32'h12340000,32'hFFFF0000,    0,0,             1,5,1, 0,0,0, 0,3);
      tbl[5]  = V(0,0,0,            0, 0,0, 0,0, 1,32'h123400BB,32'hFFFFFFFF,    0,0,             1,9,0, 0,0,0, 0,3);
      tbl[6]  = V(0,0,0,            0, 0,0, 0,0, 1,32'h0,32'h0,                  0,0,             1,3,1, 0,0,0, 0,3);
      tbl[7]  = V(0,0,0,            0, 0,0, 0,0, 1,32'h0,32'hFFFFFFFF,           0,0,             0,0,0, 0,0,0, 0,3);
      tbl[8]  = V(0,0,0,            0, 1,3, 0,0, 0,0,0,                          0,0,             0,0,0, 0,0,0, 0,2);
      tbl[9]  = V(0,0,0,            0, 1,3, 0,0, 0,0,0,                          0,0,             0,0,0, 0,0,0, 0,2);
      tbl[10] = V(0,0,0,            0, 0,0, 1,3, 0,0,0,                          0,0,             0,0,0, 0,0,0, 0,2);
      tbl[11] = V(0,0,32'h77,       1, 0,0, 0,0, 0,0,0,                          0,0,             0,0,0, 1,0,0, 0,3);
      tbl[12] = V(1,4,32'hA,        0, 1,4, 0,0, 1,32'hA,32'hFFFFFFFF,           0,0,             0,0,0, 0,0,0, 0,4);
      tbl[13] = V(0,0,0,            0, 0,0, 1,4, 0,0,0,                          1,32'hA,         0,0,0, 0,0,0, 0,4);
      tbl[14] = V(1,6,32'h55,       1, 0,0, 0,0, 0,0,0,                          0,0,             0,0,0, 0,1,0, 0,5);
      tbl[15] = V(1,1,32'h11,       0, 1,5, 0,0, 0,0,0,                          0,0,             0,0,0, 0,0,0, 0,5);
      tbl[16] = V(0,0,0,            0, 0,0, 1,5, 1,32'h123400AA,32'hFFFFFFFF,    0,0,             0,0,0, 0,0,0, 0,5);
      tbl[17] = V(0,0,0,            0, 0,0, 0,0, 0,0,0,                          0,0,             0,0,0, 0,0,0, 0,5);
      tbl[18] = V(1,0,32'h99,       0, 0,0, 1,0, 0,0,0,                          1,32'h77,        0,0,0, 0,0,0, 0,5);
      tbl[19] = V(0,0,0,            0, 0,0, 1,0, 0,0,0,                          1,32'h99,        0,0,0, 0,0,0, 0,5);
      tbl[20] = V(0,0,0,            0, 0,0, 0,0, 1,32'h0,32'h0,                  0,0,             1,0,1, 0,0,0, 0,5);
      tbl[21] = V(0,0,0,            0, 0,0, 0,0, 1,32'h99,32'hFFFFFFFF,          0,0,             1,0,0, 0,0,0, 0,5);

      drive(idle);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_u32", act32, pk(idle));
      chk("reset_u20", act20, pk(idle));
      @(negedge clk) rst = 1'b0;

      for (int k = 0; k < 22; k++) begin
         drive(tbl[k]);
         @(posedge clk); #1;
         chk($sformatf("row%0d", k), act32, pk(tbl[k]));
      end

      // Fill both arrays by allocation, then one more.
      drive(idle);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      for (int i = 0; i < 33; i++) begin
         v = V(0,0,32'(i), 1, 0,0, 0,0, 0,0,0, 0,0, 0,0,0,
               (i < 32) ? 1 : 0, (i < 32) ? 0 : 1, (i < 32) ? i : 0,
               (i >= 31) ? 1 : 0, (i < 32) ? i + 1 : 32);
         e20 = V(0,0,0, 0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0,
               (i < 20) ? 1 : 0, (i < 20) ? 0 : 1, (i < 20) ? i : 0,
               (i >= 19) ? 1 : 0, (i < 20) ? i + 1 : 20);
         drive(v);
         @(posedge clk); #1;
         chk($sformatf("alloc32_%0d", i), act32, pk(v));
         chk($sformatf("alloc20_%0d", i), act20, pk(e20));
      end

      // Freed entry is not visible to an alloc in the same cycle.
      v   = V(0,0,32'hAB, 1, 1,7, 0,0, 0,0,0, 0,0, 0,0,0, 0,1,0, 0,31);
      e20 = V(0,0,0,      0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,1,0, 0,19);
      drive(v); @(posedge clk); #1;
      chk("inval_alloc32", act32, pk(v));
      chk("inval_alloc20", act20, pk(e20));
      v   = V(0,0,32'hCD, 1, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 1,0,7, 1,32);
      e20 = V(0,0,0,      0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 1,0,7, 1,20);
      drive(v); @(posedge clk); #1;
      chk("realloc32", act32, pk(v));
      chk("realloc20", act20, pk(e20));
      v   = V(0,0,0, 0, 0,0, 1,7, 0,0,0, 1,32'hCD, 0,0,0, 0,0,0, 1,32);
      e20 = V(0,0,0, 0, 0,0, 0,0, 0,0,0, 1,32'hCD, 0,0,0, 0,0,0, 1,20);
      drive(v); @(posedge clk); #1;
      chk("read7_32", act32, pk(v));
      chk("read7_20", act20, pk(e20));

      // Out-of-range indices on the DEPTH=20 instance.
      drive(idle);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      v   = V(1,25,32'h5, 0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,1);
      e20 = V(0,0,0,      0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,0);
      drive(v); @(posedge clk); #1;
      chk("wr25_32", act32, pk(v));
      chk("wr25_20", act20, pk(e20));
      v   = V(1,19,32'h6, 0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,2);
      e20 = V(0,0,0,      0, 0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,1);
      drive(v); @(posedge clk); #1;
      chk("wr19_32", act32, pk(v));
      chk("wr19_20", act20, pk(e20));
      v   = V(0,0,0, 0, 0,0, 1,25, 0,0,0, 1,32'h5, 0,0,0, 0,0,0, 0,2);
      e20 = V(0,0,0, 0, 0,0, 0,0,  0,0,0, 0,0,     0,0,0, 0,0,0, 0,1);
      drive(v); @(posedge clk); #1;
      chk("rd25_32", act32, pk(v));
      chk("rd25_20", act20, pk(e20));
      v   = V(0,0,0, 0, 0,0, 1,19, 0,0,0, 1,32'h6, 0,0,0, 0,0,0, 0,2);
      e20 = V(0,0,0, 0, 0,0, 0,0,  0,0,0, 1,32'h6, 0,0,0, 0,0,0, 0,1);
      drive(v); @(posedge clk); #1;
      chk("rd19_32", act32, pk(v));
      chk("rd19_20", act20, pk(e20));
      v   = V(0,0,0, 0, 1,25, 0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,1);
      e20 = V(0,0,0, 0, 0,0,  0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,1);
      drive(v); @(posedge clk); #1;
      chk("inv25_32", act32, pk(v));
      chk("inv25_20", act20, pk(e20));
      v = V(0,0,0, 0, 0,0, 0,0, 1,32'h0,32'h0, 0,0, 1,19,0, 0,0,0, 0,1);
      drive(v); @(posedge clk); #1;
      chk("srch_32", act32, pk(v));
      chk("srch_20", act20, pk(v));

      // Async reset mid-search clears outputs before the next edge.
      drive(v); @(posedge clk); #1;
      chk("srch2_32", act32, pk(v));
      #2 rst = 1'b1;
      #1;
      chk("async_rst32", act32, pk(idle));
      chk("async_rst20", act20, pk(idle));
      drive(idle);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst32", act32, pk(idle));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
